alu_stream_wrapper: RTL and testbench
=====================================

ALU_STREAM_WRAPPER -- requirements
Module: alu_stream_wrapper

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; the clock is named clk and the reset is named rst.
REQ-002 Parameter WIDTH SHALL default to 8 and set the signed operand/result width; the legal range is 4..32.
REQ-003 Parameter DEPTH SHALL default to 4 and set the result FIFO depth; it SHALL be a power of two, 2..16.
REQ-004 Parameter SAT_MODE SHALL default to 0; 0 wraps ADD/SUB/MUL results and 1 saturates them.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  command present.
REQ-008 in_ready  output  1  command accepted when in_valid and in_ready are both high at a clk edge.
REQ-009 in_op  input  3  opcode.
REQ-010 in_a, in_b  input  WIDTH each  signed operands.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_ready  input  1  consumer pops the head when out_valid and out_ready are both high.
REQ-013 data_out  output  WIDTH  signed result at the FIFO head.
REQ-014 data_type  output  3  opcode that produced data_out.
REQ-015 flags  output  4  {V,C,N,Z} for the head entry.
REQ-016 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SRA, 7 MUL.
REQ-018 SHL and SRA SHALL shift in_a by in_b[clog2(WIDTH)-1:0]; SRA SHALL sign-fill.
REQ-019 MUL SHALL return the low WIDTH bits of the signed 2*WIDTH product.
REQ-020 Flag V SHALL be set on signed overflow for ADD/SUB/MUL (product outside WIDTH signed range), and SHALL be 0 otherwise.
REQ-021 Flag C SHALL be the unsigned carry-out for ADD, the unsigned borrow (a<b unsigned) for SUB, the last bit shifted out for SHL/SRA, and 0 otherwise.
REQ-022 Flags N and Z SHALL reflect the final (post-saturation) data_out.
REQ-023 When SAT_MODE=1 and V=1, the result SHALL clamp to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) according to the true sign of the exact result; V SHALL remain 1.
REQ-024 The datapath SHALL be two-stage: the accepted command is registered at edge N, and the computed result plus flags are written to the FIFO at edge N+1.
REQ-025 out_valid SHALL be high in the cycle after edge N+1 when the FIFO was empty.
REQ-026 The stage register SHALL hold at most one command; stage_valid SHALL clear when its result is written.
REQ-027 in_ready SHALL equal (level + stage_valid) < DEPTH, driven from registers only, with no combinational path from out_ready or in_valid.
REQ-028 A command SHALL never be dropped: if in_ready is high, FIFO space is guaranteed one cycle later.
REQ-029 A simultaneous FIFO write and pop SHALL leave level unchanged and be legal at any occupancy, including full.
REQ-030 Pop on empty and accept with in_ready low SHALL have no effect.
REQ-031 The FIFO read and write pointers SHALL wrap modulo DEPTH, and results SHALL emerge in acceptance order.
REQ-032 data_out, data_type and flags SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-033 While rst is low at a clk edge, the block SHALL flush the stage register and the FIFO.
REQ-034 Reset outputs SHALL be: out_valid=0, level=0, data_out=0, data_type=0, flags=0, in_ready=0.
REQ-035 in_ready SHALL rise in the first cycle after rst is sampled high.
REQ-036 Reset asserted mid-stream SHALL discard all in-flight and queued results without emitting them.

Verification (WIDTH=8, DEPTH=4)
REQ-037 ADD 100+27 -> 127, flags 0000; ADD 100+28 -> SAT_MODE=0: -128, V=1, N=1; SAT_MODE=1: 127, V=1, N=0.
REQ-038 SUB 5-5 -> 0, Z=1, C=0; SUB 3-5 -> -2, N=1, C=1; data_type=1 on both.
REQ-039 SHL 1 by 7 -> -128, N=1, C=0; SRA -128 by 3 -> -16, N=1; MUL 16*8 -> SAT_MODE=0: -128, V=1; SAT_MODE=1: 127, V=1.
REQ-040 Hold out_ready=0 and offer 6 back-to-back commands -> exactly 4 accepted, in_ready low, level=4; then set out_ready=1 -> 4 results in order one per cycle, after which the remaining commands are accepted.
REQ-041 Keep FIFO full with out_ready=1 and a continuous input stream -> throughput of one result per cycle, level constant, no loss or reordering over 20 commands.
REQ-042 Pull rst low with 3 results queued and 1 in the stage register -> next cycle out_valid=0, level=0; after release none of the 4 results ever appears.

Source files
------------

// File: rtl/alu_stream_wrapper.sv
// alu_stream_wrapper: registered ALU stage feeding a result FIFO with ready/valid on both sides
module alu_stream_wrapper #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int SAT_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           data_out,
   output logic [2:0]                 data_type,
   output logic [3:0]                 flags,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(WIDTH);
   localparam logic [AW+1:0] LIM = (AW+2)'(DEPTH);
   logic                 stage_valid_q, rdy_q;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [AW:0]          level_q;
   logic [AW-1:0]        wr_q, rd_q;
   logic [WIDTH-1:0]     data_mem [DEPTH];
   logic [2:0]           type_mem [DEPTH];
   logic [3:0]           flag_mem [DEPTH];
   logic                 accept, pop, v, c, neg;
   logic [SW-1:0]        sh;
   logic [WIDTH:0]       ext_add, ext_sub, uadd, shl_t, sra_t;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     raw, res;
   assign out_valid = level_q != '0;
   assign pop       = out_valid && out_ready;
   // stage always drains into the FIFO, so counting it against DEPTH guarantees space
   assign in_ready  = rdy_q && (({1'b0, level_q} + {{(AW+1){1'b0}}, stage_valid_q}) < LIM);
   assign accept    = in_valid && in_ready;
   assign level     = level_q;
   assign data_out  = out_valid ? data_mem[rd_q] : '0;
   assign data_type = out_valid ? type_mem[rd_q] : '0;
   assign flags     = out_valid ? flag_mem[rd_q] : '0;
   always_comb begin
      sh      = b_q[SW-1:0];
      ext_add = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
      ext_sub = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
      uadd    = {1'b0, a_q} + {1'b0, b_q};
      shl_t   = {1'b0, a_q} << sh;
      sra_t   = $unsigned($signed({a_q, 1'b0}) >>> sh);
      prod    = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
      raw     = '0;
      v       = 1'b0;
      c       = 1'b0;
      neg     = 1'b0;
      case (op_q)
         3'd0: begin
            raw = ext_add[WIDTH-1:0];
            v   = ext_add[WIDTH] ^ ext_add[WIDTH-1];
            c   = uadd[WIDTH];
            neg = ext_add[WIDTH];
         end
         3'd1: begin
            raw = ext_sub[WIDTH-1:0];
            v   = ext_sub[WIDTH] ^ ext_sub[WIDTH-1];
            c   = a_q < b_q;
            neg = ext_sub[WIDTH];
         end
         3'd2: raw = a_q & b_q;
         3'd3: raw = a_q | b_q;
         3'd4: raw = a_q ^ b_q;
         3'd5: begin
            raw = shl_t[WIDTH-1:0];
            c   = shl_t[WIDTH];
         end
         3'd6: begin
            raw = sra_t[WIDTH:1];
            c   = sra_t[0];
         end
         default: begin
            raw = prod[WIDTH-1:0];
            v   = prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[2*WIDTH-1]}};
            neg = prod[2*WIDTH-1];
         end
      endcase
      res = (SAT_MODE != 0 && v) ? (neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : raw;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_valid_q <= 1'b0;
         rdy_q         <= 1'b0;
         level_q       <= '0;
         wr_q          <= '0;
         rd_q          <= '0;
      end else begin
         rdy_q         <= 1'b1;
         stage_valid_q <= accept;
         if (stage_valid_q) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         level_q <= level_q + {{AW{1'b0}}, stage_valid_q} - {{AW{1'b0}}, pop};
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= in_op;
         a_q  <= in_a;
         b_q  <= in_b;
      end
      if (stage_valid_q) begin
         data_mem[wr_q] <= res;
         type_mem[wr_q] <= op_q;
         flag_mem[wr_q] <= {v, c, res[WIDTH-1], res == '0};
      end
   end
endmodule

// File: tb/tb_alu_stream_wrapper.sv
// tb_alu_stream_wrapper: directed checks of ALU results, flags, FIFO flow control and reset flush
module tb_alu_stream_wrapper;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [2:0] in_op = 3'd0;
   logic [7:0] in_a = 8'd0;
   logic [7:0] in_b = 8'd0;
   logic       in_ready, out_valid, s_in_ready, s_out_valid;
   logic [7:0] data_out, s_data_out;
   logic [2:0] data_type, s_data_type, level, s_level;
   logic [3:0] flags, s_flags;
   int checks = 0;
   int errors = 0;
   int sent, got, cyc, lvl_bad, seen;
   int pop_cyc [32];
   logic fire;

   always #5 clk = ~clk;

   alu_stream_wrapper #(.WIDTH(8), .DEPTH(4), .SAT_MODE(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .data_type(data_type), .flags(flags), .level(level)
   );
   alu_stream_wrapper #(.WIDTH(8), .DEPTH(4), .SAT_MODE(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid), .out_ready(out_ready),
      .data_out(s_data_out), .data_type(s_data_type), .flags(s_flags), .level(s_level)
   );

   task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, g, e);
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic [3:0] ef,
                        input logic [7:0] sd, input logic [3:0] sf);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      check($sformatf("op%0d_rdy", op), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("op%0d_early", op), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("op%0d_valid", op), 32'(out_valid), 32'd1);
      check($sformatf("op%0d_data", op), 32'(data_out), 32'(ed));
      check($sformatf("op%0d_flags", op), 32'(flags), 32'(ef));
      check($sformatf("op%0d_type", op), 32'(data_type), 32'(op));
      check($sformatf("op%0d_sat_data", op), 32'(s_data_out), 32'(sd));
      check($sformatf("op%0d_sat_flags", op), 32'(s_flags), 32'(sf));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("op%0d_drain", op), 32'(level), 32'd0);
   endtask

   // ADD (base+i)+1 stream; results must pop as base+i+1 in order
   task automatic stream(input int n, input int base);
      got     = 0;
      cyc     = 0;
      lvl_bad = 0;
      out_ready = 1'b1;
      while (got < n && cyc < 200) begin
         in_valid = sent < n;
         in_op    = 3'd0;
         in_a     = 8'(base + sent);
         in_b     = 8'd1;
         if (out_valid) begin
            check($sformatf("order%0d", got), 32'(data_out), 32'(base + got + 1));
            pop_cyc[got] = cyc;
            got++;
         end
         if (got > 1 && got < n - 1 && level != 3'd1) lvl_bad++;
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) sent++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream_count", 32'(got), 32'(n));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_type", 32'(data_type), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_ready_rise", 32'(in_ready), 32'd1);
      do_op(3'd0, 8'd100, 8'd27, 8'h7F, 4'b0000, 8'h7F, 4'b0000);
      do_op(3'd0, 8'd100, 8'd28, 8'h80, 4'b1010, 8'h7F, 4'b1000);
      do_op(3'd1, 8'd5,   8'd5,  8'h00, 4'b0001, 8'h00, 4'b0001);
      do_op(3'd1, 8'd3,   8'd5,  8'hFE, 4'b0110, 8'hFE, 4'b0110);
      do_op(3'd1, 8'h80,  8'd1,  8'h7F, 4'b1000, 8'h80, 4'b1010);
      do_op(3'd0, 8'hFF,  8'd1,  8'h00, 4'b0101, 8'h00, 4'b0101);
      do_op(3'd2, 8'hF0,  8'h3C, 8'h30, 4'b0000, 8'h30, 4'b0000);
      do_op(3'd3, 8'h0F,  8'h80, 8'h8F, 4'b0010, 8'h8F, 4'b0010);
      do_op(3'd4, 8'h55,  8'h55, 8'h00, 4'b0001, 8'h00, 4'b0001);
      do_op(3'd5, 8'd1,   8'd7,  8'h80, 4'b0010, 8'h80, 4'b0010);
      do_op(3'd5, 8'hC0,  8'd1,  8'h80, 4'b0110, 8'h80, 4'b0110);
      do_op(3'd6, 8'h80,  8'd3,  8'hF0, 4'b0010, 8'hF0, 4'b0010);
      do_op(3'd6, 8'h05,  8'd1,  8'h02, 4'b0100, 8'h02, 4'b0100);
      do_op(3'd7, 8'd16,  8'd8,  8'h80, 4'b1010, 8'h7F, 4'b1000);
      do_op(3'd7, 8'hFD,  8'd5,  8'hF1, 4'b0010, 8'hF1, 4'b0010);
      // backpressure: six offered, four fit
      sent = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_op    = 3'd0;
         in_a     = 8'(10 + sent);
         in_b     = 8'd1;
         fire = in_ready;
         @(posedge clk); #1;
         if (fire) sent++;
      end
      check("bp_accepted", 32'(sent), 32'd4);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_level", 32'(level), 32'd4);
      check("bp_hold", 32'(data_out), 32'd11);
      stream(6, 10);
      check("bp_first_pop", 32'(pop_cyc[0]), 32'd0);
      check("bp_burst", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
      // continuous streaming
      sent = 0;
      stream(20, 40);
      check("tp_span", 32'(pop_cyc[19] - pop_cyc[0]), 32'd19);
      check("tp_level", 32'(lvl_bad), 32'd0);
      // reset with three queued and one staged
      sent = 0;
      cyc  = 0;
      while (sent < 4 && cyc < 20) begin
         in_valid = 1'b1;
         in_op    = 3'd0;
         in_a     = 8'(90 + sent);
         in_b     = 8'd1;
         fire = in_ready;
         @(posedge clk); #1;
         if (fire) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      check("mr_sent", 32'(sent), 32'd4);
      check("mr_level_pre", 32'(level), 32'd3);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_level", 32'(level), 32'd0);
      check("mr_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      check("mr_flushed", 32'(seen), 32'd0);
      do_op(3'd0, 8'd2, 8'd3, 8'h05, 4'b0000, 8'h05, 4'b0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
